// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock divider controller.
//   state_e    : controller state encoding (IDLE / RUN / PEND)
//   DIV_W      : default width of the divide ratio and period counter
//   half_ceil  : ceil(n/2), computed one bit wider than n so that
//                n = 2^W-1 cannot overflow (valid for widths up to 32)
package clk_div_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  function automatic logic [32:0] half_ceil(input logic [31:0] n);
    return ({1'b0, n} + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter plus tick / divided-waveform generation.
//   clk, reset : system clock, synchronous active-high reset
//   run_i      : running in the coming cycle (0 forces counter and outputs idle)
//   load_i     : restart the period at 0 in the coming cycle (ratio commit)
//   div_i      : ratio in effect for the coming cycle
//   tick_o     : registered, high in the last cycle of each period
//   div_out_o  : registered, high while cnt < ceil(div/2)
// Both outputs are computed from the counter's next value, so in any cycle
// they describe the cnt value held in that same cycle.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             tick_o,
  output logic             div_out_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             tick_q, tick_d;
  logic             dout_q, dout_d;
  logic             wrap;
  logic [32:0]      half;

  // div_i only changes together with load_i or while idle, so comparing the
  // current count against it is the same as comparing against the old ratio.
  assign wrap = (cnt_q == div_i - WIDTH'(1));
  assign half = half_ceil(32'(div_i));

  always_comb begin
    cnt_d = '0;
    // First running cycle after idle starts at 0, as does a committed reload.
    if (run_i && run_q && !load_i && !wrap) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    tick_d = run_i && (cnt_d == div_i - WIDTH'(1));
    dout_d = run_i && (33'(cnt_d) < half);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      tick_q <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_i;
      tick_q <= tick_d;
      dout_q <= dout_d;
    end
  end

  assign tick_o    = tick_q;
  assign div_out_o = dout_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time clock divider controller: holds the active divide ratio, accepts
// new ratios over valid/ready and applies them only at period boundaries.
//   clk, reset  : system clock, synchronous active-high reset
//   en          : run enable
//   cfg_valid   : new ratio offered;  cfg_div : requested ratio
//   cfg_ready   : ratio can be accepted (low while a change is pending)
//   cfg_err     : one-cycle pulse after a ratio of 0 was accepted and dropped
//   cur_div     : ratio currently in effect
//   tick        : one-cycle pulse in the last cycle of each period
//   div_out     : divided waveform, high for ceil(N/2) cycles of each period
//   busy        : a ratio change is pending
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | en low; counter held at 0, tick/div_out low
// RUN   | counting with cur_div, nothing pending
// PEND  | counting, new ratio latched, waiting for the period boundary
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH       = DIV_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [WIDTH-1:0] cur_div,
  output logic             tick,
  output logic             div_out,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             commit_now;
  logic             xfer, legal;
  logic             core_run, core_load;
  logic             tick_w, div_out_w;

  assign xfer  = cfg_valid && cfg_ready;
  assign legal = xfer && (cfg_div != '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_div_q <= WIDTH'(DEFAULT_DIV);
      pend_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    err_d      = xfer && (cfg_div == '0);
    commit_now = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) cur_div_d = cfg_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          if (legal) cur_div_d = cfg_div;
        end else if (legal) begin
          if (tick_w) begin
            // Offered on the boundary itself: take it straight away.
            cur_div_d  = cfg_div;
            commit_now = 1'b1;
          end else begin
            pend_d  = cfg_div;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          state_d   = IDLE;
          cur_div_d = pend_q;
        end else if (tick_w) begin
          state_d    = RUN;
          cur_div_d  = pend_q;
          commit_now = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == PEND);
    cfg_ready = !busy;
    core_run  = (state_d != IDLE);
    core_load = commit_now;
  end

  clk_div_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .run_i     (core_run),
    .load_i    (core_load),
    .div_i     (cur_div_d),
    .tick_o    (tick_w),
    .div_out_o (div_out_w)
  );

  assign tick    = tick_w;
  assign div_out = div_out_w;
  assign cur_div = cur_div_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready, cfg_err, tick, div_out, busy;
  logic [7:0] cur_div;

  always #5 clk = ~clk;

  clk_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .tick      (tick),
    .div_out   (div_out),
    .busy      (busy)
  );

  typedef struct {
    logic       rst, en, vld;
    logic [7:0] div;
    logic       tick, dout, busy, rdy, err;
    logic [7:0] cur;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic rst, input logic e, input logic v,
                              input logic [7:0] d, input logic t, input logic o,
                              input logic b, input logic r, input logic er,
                              input logic [7:0] c);
    vec_t x;
    x.rst = rst; x.en = e; x.vld = v; x.div = d;
    x.tick = t; x.dout = o; x.busy = b; x.rdy = r; x.err = er; x.cur = c;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample just after the consuming edge.
  task automatic step(input logic r, input logic e, input logic v, input logic [7:0] d);
    reset = r; en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic t, input logic o, input logic b,
                         input logic r, input logic er, input logic [7:0] c);
    n_vec++;
    chk("tick", idx, 32'(tick), 32'(t));
    chk("div_out", idx, 32'(div_out), 32'(o));
    chk("busy", idx, 32'(busy), 32'(b));
    chk("cfg_ready", idx, 32'(cfg_ready), 32'(r));
    chk("cfg_err", idx, 32'(cfg_err), 32'(er));
    chk("cur_div", idx, 32'(cur_div), 32'(c));
  endtask

  initial begin
    int first_tick, n_tick, n_high;
    logic hi127, hi128;

    //              rst en vld div   tick dout busy rdy err cur
    vq.push_back(mk(1, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd2)); // 0 reset
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd2)); // N=2 cnt0
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd2));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd2));
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd2));
    vq.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd2)); // 5 idle
    vq.push_back(mk(0, 0, 1, 8'd5,   0, 0, 0, 1, 0, 8'd5)); // cfg in idle
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5)); // N=5 cnt0
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 1, 0, 8'd5)); // 10 cnt3
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd5)); // cnt4
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 1, 0, 8'd5)); // 15
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 1, 1, 8'd0,   0, 1, 0, 1, 1, 8'd5)); // ratio 0 -> err
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 0, 1, 8'd4,   0, 0, 0, 1, 0, 8'd4)); // 20
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd4)); // N=4 cnt0
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd4)); // cnt1
    vq.push_back(mk(0, 1, 1, 8'd3,   0, 0, 1, 0, 0, 8'd4)); // send 3 at cnt1
    vq.push_back(mk(0, 1, 1, 8'd7,   1, 0, 1, 0, 0, 8'd4)); // offer ignored
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd3)); // 25 N=3 cnt0
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd3));
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd3));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd3));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd3));
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd3)); // 30 tick
    vq.push_back(mk(0, 1, 1, 8'd6,   0, 1, 0, 1, 0, 8'd6)); // send on tick
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd6));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd6));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 1, 0, 8'd6));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 0, 0, 1, 0, 8'd6)); // 35
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd6));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd6));
    vq.push_back(mk(0, 1, 1, 8'd1,   0, 1, 1, 0, 0, 8'd6)); // N=1 pending
    vq.push_back(mk(0, 0, 0, 8'd0,   0, 0, 0, 1, 0, 8'd1)); // en drop commits
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 1, 0, 8'd1)); // 40 N=1
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 1, 0, 8'd1));
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 1, 0, 1, 0, 8'd1));
    vq.push_back(mk(0, 1, 1, 8'd5,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd5));
    vq.push_back(mk(1, 1, 0, 8'd0,   0, 0, 0, 1, 0, 8'd2)); // 45 reset mid-period
    vq.push_back(mk(0, 1, 0, 8'd0,   0, 1, 0, 1, 0, 8'd2));
    vq.push_back(mk(0, 1, 0, 8'd0,   1, 0, 0, 1, 0, 8'd2));

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].en, vq[i].vld, vq[i].div);
      chk_all(i, vq[i].tick, vq[i].dout, vq[i].busy, vq[i].rdy, vq[i].err, vq[i].cur);
    end

    // Largest ratio: ceil(255/2)=128 must not overflow the compare.
    step(0, 0, 0, 8'd0);
    step(0, 0, 1, 8'd255);
    chk_all(100, 0, 0, 0, 1, 0, 8'd255);
    first_tick = -1; n_tick = 0; n_high = 0; hi127 = 1'b0; hi128 = 1'b1;
    for (int i = 0; i < 510; i++) begin
      step(0, 1, 0, 8'd0);
      if (tick) begin
        n_tick++;
        if (first_tick < 0) first_tick = i;
      end
      if (div_out) n_high++;
      if (i == 127) hi127 = div_out;
      if (i == 128) hi128 = div_out;
    end
    n_vec++;
    chk("n255_first_tick", 101, 32'(first_tick), 32'd254);
    chk("n255_ticks", 101, 32'(n_tick), 32'd2);
    chk("n255_high_cycles", 101, 32'(n_high), 32'd256);
    chk("n255_cnt127_high", 101, 32'(hi127), 32'd1);
    chk("n255_cnt128_low", 101, 32'(hi128), 32'd0);

    // Reset while a change is pending discards it.
    step(0, 1, 0, 8'd0);
    step(0, 1, 1, 8'd9);
    chk_all(102, 0, 1, 1, 0, 0, 8'd255);
    step(1, 1, 0, 8'd0);
    chk_all(103, 0, 0, 0, 1, 0, 8'd2);
    step(0, 1, 0, 8'd0);
    chk_all(104, 0, 1, 0, 1, 0, 8'd2);
    step(0, 1, 0, 8'd0);
    chk_all(105, 1, 0, 0, 1, 0, 8'd2);
    step(0, 1, 0, 8'd0);
    chk_all(106, 0, 1, 0, 1, 0, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
